// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT result write-back controller.
//   wb_state_t   : controller FSM states (IDLE, RUN, DRAIN, DONE)
//   WORD_W       : width of one SRAM word / one half of a result pair
//   ADDR_W       : SRAM word-address width
//   FIFO_DEPTH   : number of result pairs buffered ahead of the SRAM port
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int WORD_W     = 128;
    localparam int PAIR_W     = 2 * WORD_W;
    localparam int ADDR_W     = 10;
    localparam int NUM_W      = 9;
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wb_state_t;

endpackage

// File: rtl/fft_wb_fifo.sv
// ---------------------------------------------------------------------------
// fft_wb_fifo
// Small synchronous FIFO holding result pairs until both halves are written.
// Besides the head entry it also exposes the entry behind the head, so the
// consumer can start on the next pair in the same cycle the head retires.
//   clk, rst   : clock, asynchronous active-high reset (pointers and count)
//   push       : write push_data at the tail (caller guarantees not full)
//   pop        : retire the head entry (caller guarantees not empty)
//   head_data  : entry at the head
//   next_data  : entry behind the head (meaningful when count >= 2)
//   count      : number of valid entries, registered
// ---------------------------------------------------------------------------
module fft_wb_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [WIDTH-1:0]             next_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Explicit wrap so the FIFO stays correct for non power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign head_data = mem[rd_ptr];
    assign next_data = mem[ptr_inc(rd_ptr)];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            // Simultaneous push and pop leave the count unchanged.
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage is not reset: entries are only read once the count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fft_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// fft_writeback_ctrl
// Writes one FFT stage's butterfly results back to SRAM. Each accepted pair
// (word1, word2) becomes two SRAM writes at addresses one half-span apart.
//   i_CLK, i_RESET          : clock, asynchronous active-high reset
//   i_START                 : one-cycle pulse in IDLE; latches i_STRIDE,
//                             i_BASE_ADDR, i_NUM_PAIRS and starts the stage
//   i_VALID / o_READY       : pair input handshake (i_READ_OUTPUT1/2)
//   o_MEM_WE/ADDR/WDATA     : registered SRAM write port
//   i_MEM_READY             : SRAM accepts the presented write this cycle
//   o_BUSY                  : stage in progress (RUN or DRAIN)
//   o_DONE                  : one-cycle pulse once the stage has fully drained
//   o_DBG_STATE             : current FSM state, for observation only
//
// Handshakes: a pair transfers on a rising edge where i_VALID && o_READY;
// a write completes on a rising edge where o_MEM_WE && i_MEM_READY, and until
// it completes the write port holds address, data and strobe unchanged.
// ---------------------------------------------------------------------------
module fft_writeback_ctrl
    import fft_pkg::*;
(
    input  logic              i_CLK,
    input  logic              i_RESET,
    input  logic              i_START,
    input  logic [9:0]        i_STRIDE,
    input  logic [9:0]        i_BASE_ADDR,
    input  logic [8:0]        i_NUM_PAIRS,
    input  logic              i_VALID,
    output logic              o_READY,
    input  logic [127:0]      i_READ_OUTPUT1,
    input  logic [127:0]      i_READ_OUTPUT2,
    output logic              o_MEM_WE,
    output logic [9:0]        o_MEM_ADDR,
    output logic [127:0]      o_MEM_WDATA,
    input  logic              i_MEM_READY,
    output logic              o_BUSY,
    output logic              o_DONE,
    output logic [1:0]        o_DBG_STATE
);

    wb_state_t state;
    wb_state_t state_next;

    // Stage parameters and address counters
    logic              small_q;      // stride < 4: pairs are adjacent words
    logic [ADDR_W-1:0] s_q;          // half-span in words (stride >> 2)
    logic [ADDR_W-1:0] group_q;      // base address of the current group
    logic [ADDR_W-1:0] j_q;          // pair index inside the group
    logic [NUM_W-1:0]  num_pairs_q;
    logic [NUM_W-1:0]  pairs_in;     // pairs accepted so far

    // Write port bookkeeping: set while the port carries word2 of the head
    logic              word2_q;

    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [PAIR_W-1:0]     head_data;
    logic [PAIR_W-1:0]     next_data;

    logic              push;
    logic              pop;
    logic              start_ok;
    logic              last_pair;
    logic              wr_done;
    logic              load_w1_head;
    logic              load_w1_next;
    logic              load_w1;
    logic              load_w2;
    logic [PAIR_W-1:0] w1_src;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] s_eff;

    // Ready depends only on registered count, so a pop at full does not
    // open the input in the same cycle.
    assign o_READY   = (state == ST_RUN) && (fifo_count < FIFO_CNT_W'(FIFO_DEPTH));
    assign push      = i_VALID && o_READY;
    assign start_ok  = i_START && (state == ST_IDLE);
    assign last_pair = (pairs_in == (num_pairs_q - NUM_W'(1)));

    assign o_BUSY      = (state == ST_RUN) || (state == ST_DRAIN);
    assign o_DONE      = (state == ST_DONE);
    assign o_DBG_STATE = state;

    fft_wb_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_CLK),
        .rst       (i_RESET),
        .push      (push),
        .push_data ({i_READ_OUTPUT2, i_READ_OUTPUT1}),
        .pop       (pop),
        .head_data (head_data),
        .next_data (next_data),
        .count     (fifo_count)
    );

    // ------------------------------------------------------------------
    // Write scheduling. The port is free when idle or when its write
    // completes this cycle. After word1 completes, word2 of the same head
    // follows; after word2 completes, the head retires and word1 of the
    // entry behind it is loaded straight away, giving one write per cycle.
    // ------------------------------------------------------------------
    assign wr_done      = o_MEM_WE && i_MEM_READY;
    assign load_w1_head = !o_MEM_WE && (fifo_count != '0);
    assign load_w1_next = wr_done && word2_q && (fifo_count >= FIFO_CNT_W'(2));
    assign load_w1      = load_w1_head || load_w1_next;
    assign load_w2      = wr_done && !word2_q;
    assign pop          = wr_done && word2_q;
    assign w1_src       = load_w1_next ? next_data : head_data;

    assign s_eff = small_q ? ADDR_W'(1) : s_q;
    assign addr1 = group_q + j_q;

    // FSM: state register
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (i_START) begin
                    state_next = (i_NUM_PAIRS == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (push && last_pair) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((fifo_count == '0) && !o_MEM_WE) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Stage parameters, address counters and the registered write port
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            small_q     <= 1'b0;
            s_q         <= '0;
            group_q     <= '0;
            j_q         <= '0;
            num_pairs_q <= '0;
            pairs_in    <= '0;
            word2_q     <= 1'b0;
            o_MEM_WE    <= 1'b0;
            o_MEM_ADDR  <= '0;
            o_MEM_WDATA <= '0;
        end else begin
            if (start_ok) begin
                small_q     <= (i_STRIDE < 10'd4);
                s_q         <= i_STRIDE >> 2;
                group_q     <= i_BASE_ADDR;
                j_q         <= '0;
                num_pairs_q <= i_NUM_PAIRS;
                pairs_in    <= '0;
            end else begin
                if (push) begin
                    pairs_in <= pairs_in + NUM_W'(1);
                end
                // Counters step once per pair, when its word1 is issued.
                // Groups of s pairs are 2s words apart; no division needed.
                if (load_w1) begin
                    if (small_q) begin
                        group_q <= group_q + ADDR_W'(2);
                    end else if (j_q == (s_q - ADDR_W'(1))) begin
                        j_q     <= '0;
                        group_q <= group_q + {s_q[ADDR_W-2:0], 1'b0};
                    end else begin
                        j_q <= j_q + ADDR_W'(1);
                    end
                end
            end

            if (load_w1) begin
                o_MEM_WE    <= 1'b1;
                o_MEM_ADDR  <= addr1;
                o_MEM_WDATA <= w1_src[WORD_W-1:0];
                word2_q     <= 1'b0;
            end else if (load_w2) begin
                // The port still shows word1's address here.
                o_MEM_WE    <= 1'b1;
                o_MEM_ADDR  <= o_MEM_ADDR + s_eff;
                o_MEM_WDATA <= head_data[PAIR_W-1:WORD_W];
                word2_q     <= 1'b1;
            end else if (wr_done) begin
                o_MEM_WE <= 1'b0;
                word2_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft_writeback_ctrl
// Directed and randomized stages against a reference model that derives
// every write address from the div/mod formula and every write datum from
// the order in which pairs were accepted.
// ---------------------------------------------------------------------------
module tb_fft_writeback_ctrl;

    logic         clk;
    logic         rst;
    logic         i_START;
    logic [9:0]   i_STRIDE;
    logic [9:0]   i_BASE_ADDR;
    logic [8:0]   i_NUM_PAIRS;
    logic         i_VALID;
    logic         o_READY;
    logic [127:0] i_READ_OUTPUT1;
    logic [127:0] i_READ_OUTPUT2;
    logic         o_MEM_WE;
    logic [9:0]   o_MEM_ADDR;
    logic [127:0] o_MEM_WDATA;
    logic         i_MEM_READY;
    logic         o_BUSY;
    logic         o_DONE;
    logic [1:0]   o_DBG_STATE;

    fft_writeback_ctrl dut (
        .i_CLK          (clk),
        .i_RESET        (rst),
        .i_START        (i_START),
        .i_STRIDE       (i_STRIDE),
        .i_BASE_ADDR    (i_BASE_ADDR),
        .i_NUM_PAIRS    (i_NUM_PAIRS),
        .i_VALID        (i_VALID),
        .o_READY        (o_READY),
        .i_READ_OUTPUT1 (i_READ_OUTPUT1),
        .i_READ_OUTPUT2 (i_READ_OUTPUT2),
        .o_MEM_WE       (o_MEM_WE),
        .o_MEM_ADDR     (o_MEM_ADDR),
        .o_MEM_WDATA    (o_MEM_WDATA),
        .i_MEM_READY    (i_MEM_READY),
        .o_BUSY         (o_BUSY),
        .o_DONE         (o_DONE),
        .o_DBG_STATE    (o_DBG_STATE)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bookkeeping ----------------
    int checks;
    int failures;

    logic [9:0]   exp_addr_q[$];
    logic [127:0] exp_q[$];
    logic [9:0]   got_addr_q[$];
    logic [127:0] got_data_q[$];
    logic [127:0] sent_q[$];

    int wr_cnt;
    int done_cnt;
    int extra_writes;
    int w0, d0, e0, g0, s0;

    // reference model state
    bit m_idle;
    bit m_active;
    int m_acc;
    int m_wr;
    int m_num;
    int m_base;
    int m_stride;

    bit           prev_stall;
    logic         h_we;
    logic [9:0]   h_addr;
    logic [127:0] h_data;

    bit mem_mode;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] ref_addr(input int base, input int stride, input int k,
                                            input bit second);
        int s;
        int a;
        s = stride >> 2;
        if (stride >= 4) begin
            a = base + (k / s) * 2 * s + (k % s);
            if (second) a = a + s;
        end else begin
            a = base + 2 * k;
            if (second) a = a + 1;
        end
        return 10'(a);
    endfunction

    // Model: watches every cycle at the falling edge, checks what the DUT
    // presents, then applies the transfers that the next rising edge makes.
    task automatic monitor_loop();
        bit exp_ready;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_addr_q.delete();
                exp_q.delete();
                m_idle     = 1'b1;
                m_active   = 1'b0;
                m_acc      = 0;
                m_wr       = 0;
                prev_stall = 1'b0;
            end else begin
                exp_ready = m_active && ((m_acc - m_wr / 2) < 4);
                check("ready", o_READY, exp_ready);
                if (prev_stall) begin
                    check("stall_we_stable", o_MEM_WE, h_we);
                    check("stall_addr_stable", o_MEM_ADDR, h_addr);
                    check("stall_data_stable", o_MEM_WDATA, h_data);
                end
                if (o_MEM_WE && i_MEM_READY) begin
                    wr_cnt++;
                    got_addr_q.push_back(o_MEM_ADDR);
                    got_data_q.push_back(o_MEM_WDATA);
                    if (exp_addr_q.size() > 0) begin
                        check("wr_addr", o_MEM_ADDR, exp_addr_q.pop_front());
                        check("wr_data", o_MEM_WDATA, exp_q.pop_front());
                    end else begin
                        extra_writes++;
                    end
                    m_wr++;
                end
                prev_stall = o_MEM_WE && !i_MEM_READY;
                h_we   = o_MEM_WE;
                h_addr = o_MEM_ADDR;
                h_data = o_MEM_WDATA;
                if (o_DONE) done_cnt++;
                if (i_VALID && o_READY) begin
                    exp_addr_q.push_back(ref_addr(m_base, m_stride, m_acc, 1'b0));
                    exp_addr_q.push_back(ref_addr(m_base, m_stride, m_acc, 1'b1));
                    exp_q.push_back(i_READ_OUTPUT1);
                    exp_q.push_back(i_READ_OUTPUT2);
                    m_acc++;
                    if (m_acc == m_num) m_active = 1'b0;
                end
                if (i_START && m_idle) begin
                    m_idle   = 1'b0;
                    m_num    = int'(i_NUM_PAIRS);
                    m_base   = int'(i_BASE_ADDR);
                    m_stride = int'(i_STRIDE);
                    m_active = (i_NUM_PAIRS != 0);
                    m_acc    = 0;
                    m_wr     = 0;
                end
                if (o_DONE) m_idle = 1'b1;
            end
        end
    endtask

    // Random SRAM back-pressure when enabled
    task automatic mem_driver();
        forever begin
            @(posedge clk);
            #2;
            if (mem_mode) i_MEM_READY = 1'($urandom_range(0, 1));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_stage(input int stride, input int base, input int num);
        w0 = wr_cnt;
        d0 = done_cnt;
        e0 = extra_writes;
        g0 = got_addr_q.size();
        s0 = sent_q.size();
        i_START     = 1'b1;
        i_STRIDE    = 10'(stride);
        i_BASE_ADDR = 10'(base);
        i_NUM_PAIRS = 9'(num);
        step();
        i_START = 1'b0;
    endtask

    task automatic send_pairs(input int n, input int max_gap);
        bit acc;
        for (int i = 0; i < n; i++) begin
            i_READ_OUTPUT1 = {$urandom, $urandom, $urandom, $urandom};
            i_READ_OUTPUT2 = {$urandom, $urandom, $urandom, $urandom};
            i_VALID = 1'b1;
            acc = 1'b0;
            for (int t = 0; t < 300; t++) begin
                @(negedge clk);
                acc = o_READY;
                step();
                if (acc) break;
            end
            check("pair_accepted", acc, 1'b1);
            sent_q.push_back(i_READ_OUTPUT1);
            sent_q.push_back(i_READ_OUTPUT2);
            i_VALID = 1'b0;
            repeat ($urandom_range(0, max_gap)) step();
        end
    endtask

    task automatic wait_done(input int budget);
        bit got;
        got = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (o_DONE) begin
                got = 1'b1;
                break;
            end
        end
        step();
        check("done_seen", got, 1'b1);
    endtask

    task automatic finish_stage(input int exp_writes);
        step();
        step();
        check("sb_empty", exp_addr_q.size(), 0);
        check("extra_writes", extra_writes - e0, 0);
        check("done_once", done_cnt - d0, 1);
        check("n_writes", wr_cnt - w0, exp_writes);
    endtask

    task automatic run_random_stage();
        int stride;
        int base;
        int n;
        stride = 1 << $urandom_range(0, 9);
        base   = $urandom_range(0, 1023);
        n      = $urandom_range(1, 24);
        mem_mode    = 1'($urandom_range(0, 1));
        i_MEM_READY = 1'b1;
        begin_stage(stride, base, n);
        check("busy_after_start", o_BUSY, 1'b1);
        send_pairs(n, 2);
        wait_done(3000);
        mem_mode = 1'b0;
        i_MEM_READY = 1'b1;
        finish_stage(2 * n);
    endtask

    // ---------------- stimulus ----------------
    logic [9:0] tbl33 [8];
    int wsnap;
    int loops;

    initial begin
        checks = 0;
        failures = 0;
        wr_cnt = 0;
        done_cnt = 0;
        extra_writes = 0;
        m_idle = 1'b1;
        m_active = 1'b0;
        prev_stall = 1'b0;
        mem_mode = 1'b0;
        rst = 1'b1;
        i_START = 1'b0;
        i_STRIDE = '0;
        i_BASE_ADDR = '0;
        i_NUM_PAIRS = '0;
        i_VALID = 1'b0;
        i_READ_OUTPUT1 = '0;
        i_READ_OUTPUT2 = '0;
        i_MEM_READY = 1'b1;
        tbl33 = '{10'h100, 10'h102, 10'h101, 10'h103, 10'h104, 10'h106, 10'h105, 10'h107};

        fork
            monitor_loop();
            mem_driver();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", o_READY, 1'b0);
        check("rst_we", o_MEM_WE, 1'b0);
        check("rst_addr", o_MEM_ADDR, 10'd0);
        check("rst_wdata", o_MEM_WDATA, 128'd0);
        check("rst_busy", o_BUSY, 1'b0);
        check("rst_done", o_DONE, 1'b0);
        rst = 1'b0;
        step();

        // Stride 8, base 0x100, four pairs, no stalls
        begin_stage(8, 'h100, 4);
        check("t33_busy", o_BUSY, 1'b1);
        send_pairs(4, 0);
        wait_done(200);
        finish_stage(8);
        for (int i = 0; i < 8; i++) check("t33_addr", got_addr_q[g0 + i], tbl33[i]);

        // Stride 2, base 0: consecutive addresses, data in arrival order
        begin_stage(2, 0, 3);
        send_pairs(3, 1);
        wait_done(200);
        finish_stage(6);
        for (int i = 0; i < 6; i++) begin
            check("t34_addr", got_addr_q[g0 + i], 10'(i));
            check("t34_data", got_data_q[g0 + i], sent_q[s0 + i]);
        end

        // SRAM stalled for 10 cycles while 6 pairs are offered
        i_MEM_READY = 1'b0;
        begin_stage(4, 'h40, 6);
        fork
            send_pairs(6, 0);
            begin
                repeat (10) step();
                check("stall_ready_low", o_READY, 1'b0);
                check("stall_we_high", o_MEM_WE, 1'b1);
                check("stall_accepted", m_acc, 4);
                i_MEM_READY = 1'b1;
            end
        join
        wait_done(300);
        finish_stage(12);
        for (int i = 0; i < 12; i++) check("t35_data", got_data_q[g0 + i], sent_q[s0 + i]);

        // Zero pairs: DONE one cycle after start, no writes
        begin_stage(8, 'h10, 0);
        @(negedge clk);
        check("zero_done", o_DONE, 1'b1);
        check("zero_busy", o_BUSY, 1'b0);
        step();
        @(negedge clk);
        check("zero_done_pulse", o_DONE, 1'b0);
        step();
        check("zero_writes", wr_cnt - w0, 0);
        check("zero_done_once", done_cnt - d0, 1);

        // Reset in the middle of a stage (addresses wrap past 0x3FF)
        begin_stage(4, 'h3FE, 4);
        send_pairs(4, 0);
        loops = 0;
        while ((wr_cnt - w0) < 2 && loops < 100) begin
            step();
            loops++;
        end
        check("mid_two_writes", (wr_cnt - w0) >= 2, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", o_READY, 1'b0);
        check("mid_rst_we", o_MEM_WE, 1'b0);
        check("mid_rst_addr", o_MEM_ADDR, 10'd0);
        check("mid_rst_wdata", o_MEM_WDATA, 128'd0);
        check("mid_rst_busy", o_BUSY, 1'b0);
        check("mid_rst_done", o_DONE, 1'b0);
        step();
        step();
        rst = 1'b0;
        wsnap = wr_cnt;
        repeat (8) step();
        check("post_rst_writes", wr_cnt - wsnap, 0);
        check("post_rst_busy", o_BUSY, 1'b0);
        mem_mode = 1'b1;
        begin_stage(16, 'h3F0, 6);
        send_pairs(6, 2);
        wait_done(1000);
        mem_mode = 1'b0;
        i_MEM_READY = 1'b1;
        finish_stage(12);

        // Start pulsed while running is ignored
        begin_stage(4, 'h20, 5);
        send_pairs(2, 0);
        i_START     = 1'b1;
        i_STRIDE    = 10'd1;
        i_BASE_ADDR = 10'h300;
        i_NUM_PAIRS = 9'd2;
        step();
        i_START = 1'b0;
        send_pairs(3, 1);
        wait_done(300);
        finish_stage(10);
        for (int i = 0; i < 10; i++) check("t38_addr", got_addr_q[g0 + i], 10'(32 + i));

        // Randomized stages
        for (int r = 0; r < 8; r++) run_random_stage();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
